// File: rtl/clk_div_pkg.sv
// Shared constants and the per-channel configuration record for clk_div_multi.
package clk_div_pkg;
  localparam int CFG_DW = 32;
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  typedef struct packed {
    logic [CFG_DW-1:0] div;
    logic              mode;
  } chan_cfg_t;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active configuration, pending flag and
// registered output. Shadow config is applied only at a period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          W       = 32,
  parameter int unsigned DEF_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic         wr_mode,
  output logic         clk_out,
  output logic         pending
);
  localparam chan_cfg_t RST_CFG = '{div: CFG_DW'(DEF_DIV), mode: MODE_TOGGLE};

  logic [W-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;
  logic         pend_q, pend_d;
  chan_cfg_t    act_q, act_d;
  chan_cfg_t    shd_q, shd_d;
  logic         wrap;
  logic         apply;

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    pend_d = pend_q;
    act_d  = act_q;
    shd_d  = shd_q;
    // >= so that a divisor lowered below the running count wraps at once
    wrap   = CFG_DW'(cnt_q) >= act_q.div;
    apply  = pend_q && (sync || !en || wrap);

    if (sync) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (!en) begin
      if (pend_q) cnt_d = '0;
      if (act_q.mode == MODE_PULSE) out_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      out_d = (act_q.mode == MODE_PULSE) ? 1'b1 : ~out_q;
    end else begin
      cnt_d = cnt_q + W'(1);
      if (act_q.mode == MODE_PULSE) out_d = 1'b0;
    end

    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      if (shd_q.mode != act_q.mode) out_d = 1'b0;
    end

    // A write lands after any apply in the same cycle, so it waits for the next boundary
    if (wr) begin
      shd_d.div  = CFG_DW'(wr_div);
      shd_d.mode = wr_mode;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      pend_q <= 1'b0;
      act_q  <= RST_CFG;
      shd_q  <= RST_CFG;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
    end
  end

  assign clk_out = out_q;
  assign pending = pend_q;
endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with glitch-free divisor updates,
// toggle/pulse modes, per-channel enable and a global phase sync.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          W       = 32,
  parameter int unsigned DEF_DIV = 100000,
  parameter int          CHW     = 2
) (
  input  logic           ClkIn,
  input  logic           rst,
  input  logic [N-1:0]   en,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic           cfg_mode,
  input  logic           sync,
  output logic [N-1:0]   ClkOut,
  output logic [N-1:0]   pending
);
  // Selects beyond N-1 match no channel, so such writes are dropped
  for (genvar i = 0; i < N; i++) begin : g_chan
    logic wr;
    assign wr = cfg_we && (cfg_ch == CHW'(i));

    clk_div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (ClkIn),
      .rst_n   (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr),
      .wr_div  (cfg_div),
      .wr_mode (cfg_mode),
      .clk_out (ClkOut[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with N=4, W=8, DEF_DIV=3.
module tb_clk_div_multi;
  logic       ClkIn;
  logic       rst;
  logic [3:0] en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       sync;
  logic [3:0] ClkOut;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(.N(4), .W(8), .DEF_DIV(3), .CHW(2)) dut (
    .ClkIn    (ClkIn),
    .rst      (rst),
    .en       (en),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .sync     (sync),
    .ClkOut   (ClkOut),
    .pending  (pending)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ClkIn);
      #1;
    end
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 4'h0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    cfg_mode = 1'b0; sync = 1'b0;
    tick(2);
    checks++; if (ClkOut !== 4'h0) begin errors++; $display("FAIL reset_clkout: got %h expected %h", ClkOut, 4'h0); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h expected %h", pending, 4'h0); end
    rst = 1'b1; en = 4'hF;
    tick(3);
    checks++; if (ClkOut !== 4'h0) begin errors++; $display("FAIL def_edge3: got %h expected %h", ClkOut, 4'h0); end
    tick(1);
    checks++; if (ClkOut !== 4'hF) begin errors++; $display("FAIL def_edge4: got %h expected %h", ClkOut, 4'hF); end
    tick(3);
    checks++; if (ClkOut !== 4'hF) begin errors++; $display("FAIL def_edge7: got %h expected %h", ClkOut, 4'hF); end
    tick(1);
    checks++; if (ClkOut !== 4'h0) begin errors++; $display("FAIL def_edge8: got %h expected %h", ClkOut, 4'h0); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL def_pending: got %h expected %h", pending, 4'h0); end
  endtask

  task automatic test_toggle_update();
    logic [3:0] exp_tab [8];
    exp_tab = '{4'hF, 4'hD, 4'hD, 4'h2, 4'h2, 4'h0, 4'h0, 4'hF};
    do_sync();
    tick(1);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1; cfg_mode = 1'b0;
    tick(1);
    cfg_we = 1'b0;
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ch1_pending_set: got %b expected %b", pending, 4'b0010); end
    tick(1);
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ch1_pending_hold: got %b expected %b", pending, 4'b0010); end
    tick(1);
    checks++; if (ClkOut !== 4'hF) begin errors++; $display("FAIL ch1_apply_out: got %h expected %h", ClkOut, 4'hF); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL ch1_apply_pending: got %b expected %b", pending, 4'h0); end
    for (int k = 0; k < 8; k++) begin
      tick(1);
      checks++;
      if (ClkOut !== exp_tab[k]) begin
        errors++; $display("FAIL ch1_period cycle %0d: got %h expected %h", k, ClkOut, exp_tab[k]);
      end
    end
  endtask

  task automatic test_pulse_mode();
    int n;
    logic e;
    do_sync();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd5; cfg_mode = 1'b1;
    tick(1);
    cfg_we = 1'b0;
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL ch2_pending: got %b expected 1", pending[2]); end
    do_sync();
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL ch2_sync_apply: got %b expected 0", pending[2]); end
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      e = (k % 6 == 0);
      checks++;
      if (ClkOut[2] !== e) begin
        errors++; $display("FAIL ch2_pulse cycle %0d: got %b expected %b", k, ClkOut[2], e);
      end
    end
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0; cfg_mode = 1'b1;
    tick(1);
    cfg_we = 1'b0;
    n = 0;
    while (pending[2] !== 1'b0 && n < 20) begin
      tick(1);
      n++;
    end
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL ch2_d0_timeout: pending got %b expected 0", pending[2]); end
    checks++; if (n !== 5) begin errors++; $display("FAIL ch2_d0_apply_delay: got %0d expected 5", n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ClkOut[2] !== 1'b1) begin
        errors++; $display("FAIL ch2_const_high cycle %0d: got %b expected 1", k, ClkOut[2]);
      end
      tick(1);
    end
  endtask

  task automatic test_overwrite();
    logic e;
    do_sync();
    tick(1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9; cfg_mode = 1'b0;
    tick(1);
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL ch0_pending_first: got %b expected 1", pending[0]); end
    cfg_div = 8'd0;
    tick(1);
    cfg_we = 1'b0;
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL ch0_pending_second: got %b expected 1", pending[0]); end
    tick(1);
    checks++; if (ClkOut[0] !== 1'b1) begin errors++; $display("FAIL ch0_wrap_out: got %b expected 1", ClkOut[0]); end
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL ch0_wrap_pending: got %b expected 0", pending[0]); end
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      e = (k % 2 == 0);
      checks++;
      if (ClkOut[0] !== e) begin
        errors++; $display("FAIL ch0_div2 cycle %0d: got %b expected %b", k, ClkOut[0], e);
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] tail;
    tail = 4'b0110;
    do_sync();
    tick(5);
    checks++; if (ClkOut[3] !== 1'b1) begin errors++; $display("FAIL ch3_pre_disable: got %b expected 1", ClkOut[3]); end
    en = 4'b0111;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++;
      if (ClkOut[3] !== 1'b1) begin
        errors++; $display("FAIL ch3_frozen cycle %0d: got %b expected 1", k, ClkOut[3]);
      end
    end
    en = 4'hF;
    tick(2);
    checks++; if (ClkOut[3] !== 1'b1) begin errors++; $display("FAIL ch3_resume_hold: got %b expected 1", ClkOut[3]); end
    tick(1);
    checks++; if (ClkOut[3] !== 1'b0) begin errors++; $display("FAIL ch3_resume_wrap: got %b expected 0", ClkOut[3]); end
    en = 4'b0111;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1; cfg_mode = 1'b0;
    tick(1);
    cfg_we = 1'b0;
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL ch3_dis_write: got %b expected 1", pending[3]); end
    tick(1);
    checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL ch3_dis_apply: got %b expected 0", pending[3]); end
    en = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checks++;
      if (ClkOut[3] !== tail[k]) begin
        errors++; $display("FAIL ch3_new_div cycle %0d: got %b expected %b", k, ClkOut[3], tail[k]);
      end
    end
  endtask

  task automatic test_sync_and_reset();
    tick(3);
    sync = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; cfg_mode = 1'b0;
    tick(1);
    sync = 1'b0; cfg_we = 1'b0;
    checks++; if (ClkOut !== 4'h0) begin errors++; $display("FAIL sync_clkout: got %h expected %h", ClkOut, 4'h0); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL sync_pending: got %b expected %b", pending, 4'b0001); end
    tick(1);
    checks++; if (ClkOut[0] !== 1'b1) begin errors++; $display("FAIL sync_ch0_wrap: got %b expected 1", ClkOut[0]); end
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL sync_ch0_apply: got %b expected 0", pending[0]); end
    tick(7);
    checks++; if (ClkOut[0] !== 1'b1) begin errors++; $display("FAIL ch0_d7_high: got %b expected 1", ClkOut[0]); end
    tick(1);
    checks++; if (ClkOut[0] !== 1'b0) begin errors++; $display("FAIL ch0_d7_fall: got %b expected 0", ClkOut[0]); end
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4; cfg_mode = 1'b0;
    tick(1);
    cfg_we = 1'b0;
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL prereset_pending: got %b expected 1", pending[2]); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (ClkOut !== 4'h0) begin errors++; $display("FAIL async_reset_clkout: got %h expected %h", ClkOut, 4'h0); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL async_reset_pending: got %b expected %b", pending, 4'h0); end
    tick(1);
    rst = 1'b1;
    tick(3);
    checks++; if (ClkOut !== 4'h0) begin errors++; $display("FAIL postreset_edge3: got %h expected %h", ClkOut, 4'h0); end
    tick(1);
    checks++; if (ClkOut !== 4'hF) begin errors++; $display("FAIL postreset_edge4: got %h expected %h", ClkOut, 4'hF); end
  endtask

  initial begin
    test_reset();
    test_toggle_update();
    test_pulse_mode();
    test_overwrite();
    test_enable();
    test_sync_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
